// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
// Responses carry no backpressure: the master consumes every beat when it is valid.
interface mem_responder_if #(
    parameter int ADDRESS_SIZE = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDRESS_SIZE-1:0] req_addr;
    logic [ADDRESS_SIZE-1:0] req_wdata;
    logic                    resp_valid;
    logic [ADDRESS_SIZE-1:0] resp_data;
    logic                    resp_last;
    logic                    resp_error;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_last,
        input  resp_error
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_last,
        output resp_error
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: single-word writes and critical-word-first line
// read bursts over a word array at BOOT_ADDRESS, with an error beat for out-of-range requests.
module mem_responder #(
    parameter int          ADDRESS_SIZE = 32,
    parameter logic [31:0] BOOT_ADDRESS = 32'h1000,
    parameter logic [31:0] MEM_SIZE     = 32'h1000,
    parameter int          LATENCY      = 5,
    parameter int          LINE_WORDS   = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int MEM_WORDS = int'(MEM_SIZE >> 2);
    localparam int IDX_W     = (MEM_WORDS > 1)  ? $clog2(MEM_WORDS)  : 1;
    localparam int LAT_W     = (LATENCY > 1)    ? $clog2(LATENCY)    : 1;
    localparam int BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [ADDRESS_SIZE-1:0] BASE      = ADDRESS_SIZE'(BOOT_ADDRESS);
    localparam logic [ADDRESS_SIZE-1:0] SPAN      = ADDRESS_SIZE'(MEM_SIZE);
    localparam logic [IDX_W-1:0]        LINE_MASK = IDX_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0]        LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [LAT_W-1:0]        LAT_ONE   = LAT_W'(1);
    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } state_t;

    state_t state, state_next;

    logic [LAT_W-1:0]        lat_cnt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic                    write_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [ADDRESS_SIZE-1:0] wdata_q;

    logic [ADDRESS_SIZE-1:0] mem [MEM_WORDS];

    logic                    accept;
    logic                    cur_write;
    logic [ADDRESS_SIZE-1:0] cur_addr;
    logic [ADDRESS_SIZE-1:0] cur_wdata;
    logic [ADDRESS_SIZE-1:0] offset;
    logic                    in_range;
    logic [IDX_W-1:0]        word_idx;
    logic [IDX_W-1:0]        line_word;
    logic                    leave_wait;
    state_t                  resp_state;
    logic                    commit;

    // In IDLE the live request is decoded, so a LATENCY=1 build can respond right after acceptance.
    assign accept    = (state == IDLE) && bus.req_valid;
    assign cur_write = (state == IDLE) ? bus.req_write : write_q;
    assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;

    assign offset    = cur_addr - BASE;
    assign in_range  = (cur_addr >= BASE) && (offset < SPAN);
    assign word_idx  = offset[IDX_W+1:2];

    // Critical word first: the offset within the line wraps, the line base stays fixed.
    assign line_word = (word_idx & ~LINE_MASK) | ((word_idx + IDX_W'(beat_cnt)) & LINE_MASK);

    assign resp_state = (cur_write || !in_range) ? WACK : BURST;

    // The counter reaches 0 on the same edge that leaves WAIT.
    assign leave_wait = (state == WAIT && lat_cnt == LAT_ONE) || (accept && LATENCY == 1);
    assign commit     = leave_wait && cur_write && in_range;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.resp_last  = 1'b0;
        bus.resp_error = 1'b0;

        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    state_next = leave_wait ? resp_state : WAIT;
                end
            end
            WAIT: begin
                if (leave_wait) begin
                    state_next = resp_state;
                end
            end
            BURST: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = mem[line_word];
                bus.resp_last  = (beat_cnt == LAST_BEAT);
                if (beat_cnt == LAST_BEAT) begin
                    state_next = IDLE;
                end
            end
            WACK: begin
                bus.resp_valid = 1'b1;
                bus.resp_last  = 1'b1;
                bus.resp_error = !in_range;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: asynchronous active-low reset; sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt  <= '0;
            beat_cnt <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            if (accept) begin
                write_q  <= bus.req_write;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                lat_cnt  <= LAT_LOAD;
                beat_cnt <= '0;
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (state == BURST) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // NOTE: the backing array has no reset, so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_idx] <= cur_wdata;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=5 instance for the main scenarios
// and one LATENCY=1 instance for the minimum-latency timing.
module tb_mem_responder;
    localparam int AS   = 32;
    localparam int LAT  = 5;
    localparam int LINE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDRESS_SIZE(AS)) bus_a ();
    mem_responder_if #(.ADDRESS_SIZE(AS)) bus_b ();

    mem_responder #(.ADDRESS_SIZE(AS), .LATENCY(LAT), .LINE_WORDS(LINE)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mem_responder #(.ADDRESS_SIZE(AS), .LATENCY(1), .LINE_WORDS(LINE)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [0:1023];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (sel == 0) begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = ad; bus_a.req_wdata = wd;
        end else begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = ad; bus_b.req_wdata = wd;
        end
    endtask

    task automatic sample(input int sel, output logic rv, output logic [31:0] rd,
                          output logic rl, output logic re, output logic rr);
        if (sel == 0) begin
            rv = bus_a.resp_valid; rd = bus_a.resp_data; rl = bus_a.resp_last;
            re = bus_a.resp_error; rr = bus_a.req_ready;
        end else begin
            rv = bus_b.resp_valid; rd = bus_b.resp_data; rl = bus_b.resp_last;
            re = bus_b.resp_error; rr = bus_b.req_ready;
        end
    endtask

    // Expected line (beat k in slot k) for a read of an in-range address, from the model.
    function automatic logic [3:0][31:0] line_exp(input logic [31:0] addr);
        logic [3:0][31:0] r;
        int idx;
        idx = int'((addr - 32'h1000) >> 2);
        for (int k = 0; k < 4; k++) r[k] = model[(idx & ~3) + ((idx + k) & 3)];
        return r;
    endfunction

    // One request; collects the response window and checks timing, beats and idle outputs.
    task automatic xact(input string tag, input int sel, input int lat, input logic wr,
                        input logic [31:0] ad, input logic [31:0] wd, input int nb,
                        input logic [3:0][31:0] exp, input logic err);
        logic rv, rl, re, rr;
        logic [31:0] rd;
        int guard, beats, first;
        logic done;
        @(negedge clk);
        drive(sel, 1'b1, wr, ad, wd);
        sample(sel, rv, rd, rl, re, rr);
        guard = 0;
        while (!rr && guard < 20) begin
            @(negedge clk);
            sample(sel, rv, rd, rl, re, rr);
            guard++;
        end
        check({tag, ".accept"}, 64'(guard < 20), 64'(1));
        beats = 0; first = -1; done = 1'b0;
        for (int n = 1; n <= lat + LINE + 3; n++) begin
            @(negedge clk);
            if (n == 1) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            sample(sel, rv, rd, rl, re, rr);
            check({tag, ".ready"}, 64'(rr), 64'(done));
            if (rv) begin
                if (first < 0) first = n;
                if (beats < nb) begin
                    check({tag, ".data"}, 64'(rd), 64'(exp[beats]));
                    check({tag, ".last"}, 64'(rl), 64'(beats == nb - 1));
                    check({tag, ".error"}, 64'(re), 64'(err));
                end
                beats++;
                if (rl) done = 1'b1;
            end else begin
                check({tag, ".idle_zero"}, {31'h0, rl, re, rd}, 64'h0);
            end
        end
        check({tag, ".first_beat"}, 64'(first), 64'(lat));
        check({tag, ".beats"}, 64'(beats), 64'(nb));
    endtask

    initial begin
        logic rv, rl, re, rr;
        logic [31:0] rd;
        logic [3:0][31:0] e;
        int acc[$];
        int lst[$];
        logic [31:0] got[$];
        logic [31:0] held_exp [8];

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        @(negedge clk);
        sample(0, rv, rd, rl, re, rr);
        check("rst.ready", 64'(rr), 64'(1));
        check("rst.valid", 64'(rv), 64'(0));
        check("rst.last", 64'(rl), 64'(0));
        check("rst.error", 64'(re), 64'(0));
        check("rst.data", 64'(rd), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Preload words 0..7 and the last line of the window (1020..1023)
        for (int i = 0; i < 8; i++) begin
            model[i] = 32'hC0DE_0000 + 32'(i);
            xact("wr_pre", 0, LAT, 1'b1, 32'h1000 + 32'(4 * i), model[i], 1, '0, 1'b0);
        end
        for (int i = 1020; i < 1024; i++) begin
            model[i] = 32'h7700_0000 + 32'(i);
            xact("wr_top", 0, LAT, 1'b1, 32'h1000 + 32'(4 * i), model[i], 1, '0, 1'b0);
        end

        // Write then read 0x1008: beats are words 2,3,0,1
        xact("wr_1008", 0, LAT, 1'b1, 32'h1008, 32'hDEAD_BEEF, 1, '0, 1'b0);
        model[2] = 32'hDEAD_BEEF;
        e = {32'hC0DE_0001, 32'hC0DE_0000, 32'hC0DE_0003, 32'hDEAD_BEEF};
        xact("rd_1008", 0, LAT, 1'b0, 32'h1008, 32'h0, 4, e, 1'b0);

        // Wrap within the line: 0x100C gives words 3,0,1,2
        e = {32'hDEAD_BEEF, 32'hC0DE_0001, 32'hC0DE_0000, 32'hC0DE_0003};
        xact("rd_100c", 0, LAT, 1'b0, 32'h100C, 32'h0, 4, e, 1'b0);
        xact("rd_1014", 0, LAT, 1'b0, 32'h1014, 32'h0, 4, line_exp(32'h1014), 1'b0);
        xact("rd_1ff8", 0, LAT, 1'b0, 32'h1FF8, 32'h0, 4, line_exp(32'h1FF8), 1'b0);

        // Out-of-range requests on both sides of the window
        xact("rd_0ffc", 0, LAT, 1'b0, 32'h0FFC, 32'h0, 1, '0, 1'b1);
        xact("wr_2000", 0, LAT, 1'b1, 32'h2000, 32'h5555_AAAA, 1, '0, 1'b1);
        xact("rd_1000", 0, LAT, 1'b0, 32'h1000, 32'h0, 4, line_exp(32'h1000), 1'b0);

        // req_valid held high across two reads; the address change during the first is ignored
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            sample(0, rv, rd, rl, re, rr);
            if (rv) begin
                got.push_back(rd);
                if (rl) lst.push_back(c);
            end
            if (acc.size() == 1 && c == acc[0] + 1) drive(0, 1'b1, 1'b0, 32'h1010, 32'h0);
            if (acc.size() == 2 && c == acc[1] + 1) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (rr && bus_a.req_valid) acc.push_back(c);
        end
        check("held.accepts", 64'(acc.size()), 64'(2));
        check("held.lasts", 64'(lst.size()), 64'(2));
        check("held.beats", 64'(got.size()), 64'(8));
        if (acc.size() >= 2 && lst.size() >= 1) begin
            check("held.first_to_last", 64'(lst[0] - acc[0]), 64'(LAT + 3));
            check("held.reaccept_gap", 64'(acc[1] - lst[0]), 64'(1));
        end
        for (int k = 0; k < 8; k++) held_exp[k] = model[k];
        for (int k = 0; k < 8 && k < got.size(); k++) check("held.data", 64'(got[k]), 64'(held_exp[k]));

        // Reset in the middle of a burst: outputs drop at once, no further beats
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        sample(0, rv, rd, rl, re, rr);
        check("rst_burst.pre_valid", 64'(rv), 64'(1));
        reset = 1'b0;
        #1;
        sample(0, rv, rd, rl, re, rr);
        check("rst_burst.valid", 64'(rv), 64'(0));
        check("rst_burst.data", 64'(rd), 64'(0));
        check("rst_burst.ready", 64'(rr), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            sample(0, rv, rd, rl, re, rr);
            check("rst_burst.no_beat", 64'(rv), 64'(0));
        end

        // Reset during WAIT of a write to 0x1010: write is dropped
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h1010, 32'h1234_5678);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(0, rv, rd, rl, re, rr);
        check("rst_wait.busy", 64'(rr), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        sample(0, rv, rd, rl, re, rr);
        check("rst_wait.outputs", {31'h0, rv, rl, re, rd}, 64'h0);
        check("rst_wait.ready", 64'(rr), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            sample(0, rv, rd, rl, re, rr);
            check("rst_wait.no_beat", 64'(rv), 64'(0));
        end
        e = {32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004};
        xact("rd_1010", 0, LAT, 1'b0, 32'h1010, 32'h0, 4, e, 1'b0);

        // LATENCY=1 instance: beat in the cycle right after acceptance
        for (int i = 0; i < 4; i++)
            xact("b_wr", 1, 1, 1'b1, 32'h1000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1, '0, 1'b0);
        e = {32'hB000_0000, 32'hB000_0003, 32'hB000_0002, 32'hB000_0001};
        xact("b_rd_1004", 1, 1, 1'b0, 32'h1004, 32'h0, 4, e, 1'b0);
        xact("b_rd_err", 1, 1, 1'b0, 32'h0000_0000, 32'h0, 1, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 32, meaning address and data word width in bits.
REQ-002 SHALL have parameter BOOT_ADDRESS, default 32'h1000, meaning the byte address of the first backing-memory word.
REQ-003 SHALL have parameter MEM_SIZE, default 32'h1000, meaning the backing-memory size in bytes.
REQ-004 SHALL have parameter LATENCY, default 5, meaning the number of cycles from request acceptance to the first response beat (minimum 1).
REQ-005 SHALL have parameter LINE_WORDS, default 4, meaning the number of words per read burst (power of two).
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 reset  input  1  reset; asynchronous, active-low.
REQ-008 req_valid  input  1  initiator presents a request.
REQ-009 req_ready  output  1  responder can accept a request.
REQ-010 req_write  input  1  1 = single-word write, 0 = line read burst.
REQ-011 req_addr  input  ADDRESS_SIZE  byte address; bits [1:0] ignored.
REQ-012 req_wdata  input  ADDRESS_SIZE  write data.
REQ-013 resp_valid  output  1  response beat valid this cycle.
REQ-014 resp_data  output  ADDRESS_SIZE  read data; 0 on write acks and errors.
REQ-015 resp_last  output  1  final beat of the response.
REQ-016 resp_error  output  1  request address out of range.

Function
REQ-017 SHALL be a responder with no backpressure on responses: the initiator must consume every beat in the cycle it is presented.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready, and SHALL latch req_write, req_addr and req_wdata at that edge.
REQ-019 SHALL drive req_ready = 1 only in state IDLE.
REQ-020 SHALL implement states IDLE, WAIT, BURST and WACK.
- IDLE -> WAIT on acceptance.
- WAIT: a latency counter is loaded with LATENCY-1 at acceptance and decrements each cycle.
- WAIT -> BURST (read) or WACK (write) when the counter reaches 0.
REQ-021 SHALL make the first response beat valid exactly LATENCY cycles after the accepting edge.
REQ-022 In-range rule: an address is in range iff BOOT_ADDRESS <= addr < BOOT_ADDRESS+MEM_SIZE.
- Word index = (addr-BOOT_ADDRESS)>>2.
REQ-023 Read, in range: BURST SHALL emit LINE_WORDS consecutive beats, critical word first.
- Word index sequence: line base + ((w + k) mod LINE_WORDS), k = 0..LINE_WORDS-1, where w is the word offset within the line.
- resp_last SHALL be set on beat LINE_WORDS-1.
- State returns to IDLE the cycle after the last beat.
REQ-024 Write, in range: SHALL store req_wdata at the word index at the WAIT->WACK transition.
- WACK SHALL emit one beat with resp_last=1 and resp_data=0, then return to IDLE.
REQ-025 Out-of-range request (read or write): SHALL emit a single beat with resp_error=1, resp_last=1, resp_data=0 after LATENCY cycles, and SHALL NOT write memory.
REQ-026 resp_error, resp_last and resp_data SHALL be 0 whenever resp_valid=0.
REQ-027 SHALL NOT accept a new request in the cycle of the last beat; req_ready SHALL rise in the following cycle.
REQ-028 An unaccepted req_valid (state not IDLE) SHALL have no effect.
REQ-029 Read-after-write to the same word SHALL return the written value.

Reset
REQ-030 reset low SHALL immediately force state IDLE, latency counter 0, beat counter 0, req_ready=1, resp_valid=0, resp_last=0, resp_error=0, resp_data=0.
REQ-031 Reset mid-operation SHALL abort the transaction with no further beats.
- A write not yet committed SHALL be dropped.
REQ-032 Backing-memory contents SHALL NOT be altered by reset.

Verification
REQ-033 Write 32'hDEADBEEF to 32'h1008, then read 32'h1008 -> write ack at accept+5 with resp_last=1; read beats at accept+5..+8 with data from words 2,3,0,1, beat 0 = 32'hDEADBEEF, resp_last on beat 3.
REQ-034 Read 32'h100C (w=3) -> word order 3,0,1,2 (wrap-around within the line).
REQ-035 Read 32'h0FFC and write 32'h2000 -> one beat each, resp_error=1, resp_data=0; a subsequent read of 32'h1000 shows memory unchanged.
REQ-036 req_valid held high continuously -> req_ready=0 from accept to last beat; next accept exactly one cycle after resp_last; no request lost or duplicated.
REQ-037 reset low during WAIT of a write to 32'h1010 -> outputs zero immediately; after release, read of 32'h1010 returns the old value.
REQ-038 LATENCY=1 build -> first beat in the cycle immediately after acceptance.
